// File: rtl/joy_pkg.sv
// Shared types and default configuration for the joystick/button controller.
package joy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        ACTIVE = 2'd2
    } reset_state_t;

    localparam int          C_DEF_CHANNELS       = 12;
    localparam int          C_DEF_ACTIVE_LOW     = 1;
    localparam int          C_DEF_DEBOUNCE_BITS  = 16;
    localparam int          C_DEF_HOLD_BITS      = 24;
    localparam int          C_DEF_RESET_CH       = 11;
    localparam int          C_DEF_NMI_CH         = 10;
    localparam int          C_DEF_AUTOFIRE_BITS  = 20;
    localparam logic [31:0] C_DEF_AUTOFIRE_MASK  = 32'd0;

endpackage

// File: rtl/joy_debounce.sv
// One input channel: two-flop synchronizer, stability counter, debounced
// state and one-cycle press/release pulses.
module joy_debounce #(
    parameter int C_active_low    = 1,
    parameter int C_debounce_bits = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic out_stable,
    output logic out_press,
    output logic out_release
);

    logic                       r_sync1;
    logic                       r_sync2;
    logic                       r_stable;
    logic                       r_press;
    logic                       r_release;
    logic [C_debounce_bits-1:0] r_cnt;

    logic w_norm;
    logic w_differ;
    logic w_done;

    // Polarity is folded in ahead of the first flop so that the cleared
    // synchronizer reads as "not pressed".
    assign w_norm   = (C_active_low != 0) ? ~in_raw : in_raw;
    assign w_differ = (r_sync2 != r_stable);
    assign w_done   = w_differ && (r_cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= w_norm;
            r_sync2   <= r_sync1;
            r_press   <= w_done & r_sync2;
            r_release <= w_done & ~r_sync2;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + C_debounce_bits'(1);
            end
        end
    end

    assign out_stable  = r_stable;
    assign out_press   = r_press;
    assign out_release = r_release;

endmodule

// File: rtl/joy_button_ctrl.sv
// Debounced button/joystick front end with long-press reset and NMI pulse.
// Optional autofire on selected channels is built when JOY_AUTOFIRE_EN is defined.
module joy_button_ctrl
    import joy_pkg::*;
#(
    parameter int          C_channels      = C_DEF_CHANNELS,
    parameter int          C_active_low    = C_DEF_ACTIVE_LOW,
    parameter int          C_debounce_bits = C_DEF_DEBOUNCE_BITS,
    parameter int          C_hold_bits     = C_DEF_HOLD_BITS,
    parameter int          C_reset_ch      = C_DEF_RESET_CH,
    parameter int          C_nmi_ch        = C_DEF_NMI_CH,
    parameter int          C_autofire_bits = C_DEF_AUTOFIRE_BITS,
    parameter logic [31:0] C_autofire_mask = C_DEF_AUTOFIRE_MASK
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [C_channels-1:0] in_raw,
    output logic [C_channels-1:0] out_state,
    output logic [C_channels-1:0] out_press,
    output logic [C_channels-1:0] out_release,
    output logic                  out_reset,
    output logic                  out_nmi
);

    logic [C_channels-1:0] w_stable;
    logic [C_channels-1:0] w_press;
    logic [C_channels-1:0] w_release;

`ifdef JOY_AUTOFIRE_EN
    logic [C_autofire_bits-1:0] r_af_cnt;
    logic                       r_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_af_cnt <= '0;
            r_phase  <= 1'b0;
        end else begin
            r_af_cnt <= r_af_cnt + C_autofire_bits'(1);
            if (r_af_cnt == '1) begin
                r_phase <= ~r_phase;
            end
        end
    end
`endif

    for (genvar g = 0; g < C_channels; g++) begin : g_ch
        joy_debounce #(
            .C_active_low    (C_active_low),
            .C_debounce_bits (C_debounce_bits)
        ) u_deb (
            .clk         (clk),
            .reset       (reset),
            .in_raw      (in_raw[g]),
            .out_stable  (w_stable[g]),
            .out_press   (w_press[g]),
            .out_release (w_release[g])
        );

`ifdef JOY_AUTOFIRE_EN
        localparam bit C_AF = C_autofire_mask[g] && (g != C_reset_ch) && (g != C_nmi_ch);

        if (C_AF) begin : g_af
            // Gated state is re-registered so its edge pulses line up with it.
            logic r_af_state;
            logic r_af_press;
            logic r_af_release;
            logic w_af_next;

            assign w_af_next = w_stable[g] & r_phase;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_af_state   <= 1'b0;
                    r_af_press   <= 1'b0;
                    r_af_release <= 1'b0;
                end else begin
                    r_af_state   <= w_af_next;
                    r_af_press   <= w_af_next & ~r_af_state;
                    r_af_release <= ~w_af_next & r_af_state;
                end
            end

            assign out_state[g]   = r_af_state;
            assign out_press[g]   = r_af_press;
            assign out_release[g] = r_af_release;
        end else begin : g_plain
            assign out_state[g]   = w_stable[g];
            assign out_press[g]   = w_press[g];
            assign out_release[g] = w_release[g];
        end
`else
        assign out_state[g]   = w_stable[g];
        assign out_press[g]   = w_press[g];
        assign out_release[g] = w_release[g];
`endif
    end

    assign out_nmi = out_press[C_nmi_ch];

    reset_state_t           r_state;
    reset_state_t           w_state_next;
    logic [C_hold_bits-1:0] r_hcnt;
    logic [C_hold_bits-1:0] w_hcnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hcnt  <= w_hcnt_next;
        end
    end

    // HOLD is entered one cycle after the press pulse, so the transition to
    // ACTIVE fires on the edge where the counter arrives at all-ones; this
    // puts out_reset exactly 2**C_hold_bits cycles after the press.
    always_comb begin
        w_state_next = r_state;
        w_hcnt_next  = r_hcnt;
        case (r_state)
            IDLE: begin
                if (w_press[C_reset_ch]) begin
                    w_state_next = HOLD;
                    w_hcnt_next  = '0;
                end
            end
            HOLD: begin
                if (w_release[C_reset_ch]) begin
                    w_state_next = IDLE;
                end else if (r_hcnt == '1) begin
                    w_state_next = ACTIVE;
                end else begin
                    if (r_hcnt == {{(C_hold_bits-1){1'b1}}, 1'b0}) begin
                        w_state_next = ACTIVE;
                    end
                    w_hcnt_next = r_hcnt + C_hold_bits'(1);
                end
            end
            ACTIVE: begin
                if (w_release[C_reset_ch]) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_hcnt_next  = '0;
            end
        endcase
    end

    // Drop the request in the same cycle the release pulse is seen.
    assign out_reset = (r_state == ACTIVE) && !w_release[C_reset_ch];

endmodule

// File: tb/tb_joy_button_ctrl.sv
// Directed bench for joy_button_ctrl with short debounce/hold windows.
module tb_joy_button_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] in_raw;
    logic [11:0] out_state;
    logic [11:0] out_press;
    logic [11:0] out_release;
    logic        out_reset;
    logic        out_nmi;

    int n_checks  = 0;
    int n_errors  = 0;
    int nmi_seen  = 0;
    int rst_seen  = 0;

    joy_button_ctrl #(
        .C_channels      (12),
        .C_active_low    (1),
        .C_debounce_bits (4),
        .C_hold_bits     (6),
        .C_reset_ch      (11),
        .C_nmi_ch        (10),
        .C_autofire_bits (20),
        .C_autofire_mask (32'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_raw      (in_raw),
        .out_state   (out_state),
        .out_press   (out_press),
        .out_release (out_release),
        .out_reset   (out_reset),
        .out_nmi     (out_nmi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            nmi_seen += int'(out_nmi);
            rst_seen += int'(out_reset);
        end
    endtask

    initial begin
        reset  = 1'b1;
        in_raw = 12'hFFF;
        run(3);
        chk("rst_state",   32'(out_state),   32'h0);
        chk("rst_press",   32'(out_press),   32'h0);
        chk("rst_release", 32'(out_release), 32'h0);
        chk("rst_reset",   32'(out_reset),   32'h0);
        chk("rst_nmi",     32'(out_nmi),     32'h0);
        reset = 1'b0;
        run(5);

        // Clean press on channel 0
        in_raw[0] = 1'b0;
        run(17);
        chk("c0_press_17",  32'(out_press[0]), 32'h0);
        chk("c0_state_17",  32'(out_state[0]), 32'h0);
        run(1);
        chk("c0_press_18",  32'(out_press[0]), 32'h1);
        chk("c0_state_18",  32'(out_state[0]), 32'h1);
        chk("c0_rel_18",    32'(out_release[0]), 32'h0);
        run(1);
        chk("c0_press_19",  32'(out_press[0]), 32'h0);
        chk("c0_state_19",  32'(out_state[0]), 32'h1);
        in_raw[0] = 1'b1;
        run(17);
        chk("c0_rel_17",    32'(out_release[0]), 32'h0);
        run(1);
        chk("c0_rel_18",    32'(out_release[0]), 32'h1);
        chk("c0_state_rel", 32'(out_state[0]), 32'h0);
        chk("c0_press_rel", 32'(out_press[0]), 32'h0);
        run(5);

        // Bounce: 10 low, 1 high, low again
        in_raw[0] = 1'b0;
        run(10);
        in_raw[0] = 1'b1;
        run(1);
        in_raw[0] = 1'b0;
        run(17);
        chk("bnc_state_17", 32'(out_state[0]), 32'h0);
        run(1);
        chk("bnc_press_18", 32'(out_press[0]), 32'h1);
        in_raw[0] = 1'b1;
        run(20);
        chk("bnc_state_off", 32'(out_state[0]), 32'h0);

        // Long press on reset channel
        in_raw[11] = 1'b0;
        run(18);
        chk("lp_press",    32'(out_press[11]), 32'h1);
        chk("lp_rst_18",   32'(out_reset), 32'h0);
        run(63);
        chk("lp_rst_81",   32'(out_reset), 32'h0);
        run(1);
        chk("lp_rst_82",   32'(out_reset), 32'h1);
        run(118);
        chk("lp_rst_200",  32'(out_reset), 32'h1);
        in_raw[11] = 1'b1;
        run(17);
        chk("lp_rel_17",   32'(out_reset), 32'h1);
        run(1);
        chk("lp_rel_18",   32'(out_reset), 32'h0);
        chk("lp_relp_18",  32'(out_release[11]), 32'h1);
        run(1);
        chk("lp_rel_19",   32'(out_reset), 32'h0);
        run(2);

        // Short press on reset channel
        rst_seen = 0;
        in_raw[11] = 1'b0;
        run(18);
        chk("sp_press",    32'(out_press[11]), 32'h1);
        run(22);
        in_raw[11] = 1'b1;
        run(18);
        chk("sp_release",  32'(out_release[11]), 32'h1);
        chk("sp_no_reset", 32'(rst_seen), 32'h0);
        run(2);

        // NMI and reset channels together
        nmi_seen = 0;
        in_raw[10] = 1'b0;
        in_raw[11] = 1'b0;
        run(17);
        chk("nr_nmi_17",   32'(out_nmi), 32'h0);
        run(1);
        chk("nr_nmi_18",   32'(out_nmi), 32'h1);
        run(1);
        chk("nr_nmi_19",   32'(out_nmi), 32'h0);
        run(62);
        chk("nr_rst_81",   32'(out_reset), 32'h0);
        run(1);
        chk("nr_rst_82",   32'(out_reset), 32'h1);
        run(20);
        chk("nr_nmi_once", 32'(nmi_seen), 32'h1);
        chk("nr_rst_hold", 32'(out_reset), 32'h1);
        in_raw[10] = 1'b1;
        in_raw[11] = 1'b1;
        run(20);
        chk("nr_rst_off",  32'(out_reset), 32'h0);

        // Reset mid-hold discards progress
        in_raw[11] = 1'b0;
        run(50);
        reset = 1'b1;
        #1;
        chk("mr_state",    32'(out_state), 32'h0);
        chk("mr_press",    32'(out_press), 32'h0);
        chk("mr_reset",    32'(out_reset), 32'h0);
        chk("mr_nmi",      32'(out_nmi),   32'h0);
        run(2);
        reset = 1'b0;
        run(17);
        chk("mr_state_17", 32'(out_state[11]), 32'h0);
        run(1);
        chk("mr_press_18", 32'(out_press[11]), 32'h1);
        run(63);
        chk("mr_rst_81",   32'(out_reset), 32'h0);
        run(1);
        chk("mr_rst_82",   32'(out_reset), 32'h1);
        in_raw[11] = 1'b1;
        run(20);
        chk("mr_end",      32'(out_state), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
